// File: rtl/harz_pkg.sv
// Shared HARZ80 host-port types and helpers used by the bus front end and other masters.
// Request kinds, host command bytes and the multi-byte length encoding live here.
package harz_pkg;

  localparam int unsigned HARZ_MAX_BURST = 4;

  typedef enum logic [3:0] {
    HARZ80_NONE        = 4'h0,
    HARZ80_MEM_READ_1  = 4'h1,
    HARZ80_MEM_WRITE_1 = 4'h2,
    HARZ80_IO_READ     = 4'h3,
    HARZ80_IO_WRITE    = 4'h4,
    HARZ80_MEM_READ_N  = 4'h5,
    HARZ80_MEM_WRITE_N = 4'h6
  } harz_req_t;

  typedef enum logic [7:0] {
    TXCMD_NOP       = 8'h00,
    TXCMD_Z80MEM_RD = 8'h10,
    TXCMD_Z80MEM_WR = 8'h20,
    TXCMD_Z80IO_RD  = 8'h30,
    TXCMD_Z80IO_WR  = 8'h40
  } txcmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitHi,
    StWaitLo,
    StAck
  } arb_state_e;

  function automatic logic harz_is_read(harz_req_t kind);
    return (kind == HARZ80_MEM_READ_1) || (kind == HARZ80_IO_READ) ||
           (kind == HARZ80_MEM_READ_N);
  endfunction

  function automatic logic harz_is_io(harz_req_t kind);
    return (kind == HARZ80_IO_READ) || (kind == HARZ80_IO_WRITE);
  endfunction

  // Multi-byte Z80MEM commands carry the burst length in two bits: 1/2/4 bytes -> 0/1/2.
  function automatic logic [1:0] harz_len_enc(logic [2:0] len);
    logic [1:0] enc;
    enc = 2'd0;
    if (len >= 3'd4) begin
      enc = 2'd2;
    end else if (len >= 3'd2) begin
      enc = 2'd1;
    end
    return enc;
  endfunction

endpackage

// File: rtl/harz_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping.
// Purely combinational; the owner keeps the pointer register.
module harz_rr_arbiter #(
  parameter int unsigned  NumCh = 2,
  localparam int unsigned IdxW  = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic [NumCh-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NumCh-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumCh);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/harzbus_burst_arb.sv
// Multi-channel burst front end for the HARZ80 host port: round-robin grant, per-byte
// host handshakes, little-endian packing of read bytes into one word per transaction.
module harzbus_burst_arb
  import harz_pkg::*;
#(
  parameter int unsigned  NUM_CH    = 2,
  parameter int unsigned  MAX_BYTES = 4,
  localparam int unsigned DW        = 8 * MAX_BYTES
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NUM_CH-1:0]    ch_req_i,
  input  logic [4*NUM_CH-1:0]  ch_kind_i,
  input  logic [3*NUM_CH-1:0]  ch_len_i,
  input  logic [16*NUM_CH-1:0] ch_addr_i,
  input  logic [DW*NUM_CH-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]    ch_ack_o,
  output logic [DW-1:0]        ch_rdata_o,
  output harz_req_t            hb_request_o,
  output logic [15:0]          hb_address_o,
  output logic [7:0]           hb_write_data_o,
  input  logic [7:0]           hb_read_data_i,
  input  logic                 hb_busy_i,
  output logic                 arb_busy_o
);

  localparam int unsigned IdxW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BW     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [2:0]  MaxLen = 3'(MAX_BYTES);

  typedef logic [MAX_BYTES-1:0][7:0] word_t;

  logic [3:0]  kind_arr  [NUM_CH];
  logic [2:0]  len_arr   [NUM_CH];
  logic [15:0] addr_arr  [NUM_CH];
  word_t       wdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign kind_arr[g]  = ch_kind_i[4*g +: 4];
    assign len_arr[g]   = ch_len_i[3*g +: 3];
    assign addr_arr[g]  = ch_addr_i[16*g +: 16];
    assign wdata_arr[g] = ch_wdata_i[DW*g +: DW];
  end

  arb_state_e        state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   grant_q;
  logic [NUM_CH-1:0] gnt_oh_q;
  harz_req_t         kind_q;
  logic [15:0]       addr_q;
  word_t             wdata_q;
  word_t             rword_q;
  word_t             ch_rdata_q;
  logic [2:0]        len_q;
  logic [2:0]        idx_q;
  logic [NUM_CH-1:0] ch_ack_q;
  harz_req_t         hb_request_q;
  logic [15:0]       hb_address_q;
  logic [7:0]        hb_wdata_q;

  logic [NUM_CH-1:0] req_masked;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_valid;
  harz_req_t         sel_kind;
  logic [2:0]        sel_len;
  logic [2:0]        sel_len_eff;
  logic [BW-1:0]     byte_sel;
  logic [IdxW-1:0]   rr_next;

  // Requests are ignored while an ack is on the wire so the acked client can drop first.
  assign req_masked = ch_req_i & {NUM_CH{~|ch_ack_q}};

  harz_rr_arbiter #(
    .NumCh (NUM_CH)
  ) u_rr_arbiter (
    .req_i   (req_masked),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_kind    = harz_req_t'(kind_arr[arb_idx]);
  assign sel_len     = len_arr[arb_idx];
  assign sel_len_eff = (sel_len > MaxLen) ? MaxLen : sel_len;
  assign byte_sel    = idx_q[BW-1:0];
  assign rr_next     = (grant_q == IdxW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      gnt_oh_q     <= '0;
      kind_q       <= HARZ80_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rword_q      <= '0;
      ch_rdata_q   <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      ch_ack_q     <= '0;
      hb_request_q <= HARZ80_NONE;
      hb_address_q <= '0;
      hb_wdata_q   <= '0;
    end else begin
      ch_ack_q     <= '0;
      hb_request_q <= HARZ80_NONE;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            grant_q  <= arb_idx;
            gnt_oh_q <= arb_gnt;
            kind_q   <= sel_kind;
            addr_q   <= addr_arr[arb_idx];
            wdata_q  <= wdata_arr[arb_idx];
            len_q    <= sel_len_eff;
            idx_q    <= '0;
            rword_q  <= '0;
            state_q  <= ((sel_len_eff == 3'd0) || (sel_kind == HARZ80_NONE)) ? StAck : StIssue;
          end
        end
        StIssue: begin
          if (!hb_busy_i) begin
            hb_request_q <= kind_q;
            hb_address_q <= addr_q;
            hb_wdata_q   <= wdata_q[byte_sel];
            state_q      <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (hb_busy_i) begin
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (!hb_busy_i) begin
            if (harz_is_read(kind_q)) begin
              rword_q[byte_sel] <= hb_read_data_i;
            end
            // IO ports are FIFO-style, so only memory bursts walk the address.
            if (!harz_is_io(kind_q)) begin
              addr_q <= addr_q + 16'd1;
            end
            idx_q   <= idx_q + 3'd1;
            state_q <= ((idx_q + 3'd1) == len_q) ? StAck : StIssue;
          end
        end
        StAck: begin
          ch_ack_q   <= gnt_oh_q;
          ch_rdata_q <= rword_q;
          rr_ptr_q   <= rr_next;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_ack_o        = ch_ack_q;
  assign ch_rdata_o      = ch_rdata_q;
  assign hb_request_o    = hb_request_q;
  assign hb_address_o    = hb_address_q;
  assign hb_write_data_o = hb_wdata_q;
  assign arb_busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_harzbus_burst_arb.sv
// Directed bench for harzbus_burst_arb with a behavioural HARZ80 host and an ack monitor.
`timescale 1ns/1ps
module tb_harzbus_burst_arb;
  import harz_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  ch_req = '0;
  logic [7:0]  ch_kind = '0;
  logic [5:0]  ch_len = '0;
  logic [31:0] ch_addr = '0;
  logic [63:0] ch_wdata = '0;
  logic [1:0]  ch_ack;
  logic [31:0] ch_rdata;
  harz_req_t   hb_request;
  logic [15:0] hb_address;
  logic [7:0]  hb_write_data;
  logic [7:0]  hb_read_data = '0;
  logic        hb_busy = 1'b0;
  logic        arb_busy;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 1;
  int ack_cnt = 0;
  logic host_rd;

  logic [7:0]  rd_q [$];
  harz_req_t   log_kind [$];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          ack_order [$];
  logic [31:0] ack_rdata [$];

  harzbus_burst_arb #(
    .NUM_CH    (2),
    .MAX_BYTES (4)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .ch_req_i        (ch_req),
    .ch_kind_i       (ch_kind),
    .ch_len_i        (ch_len),
    .ch_addr_i       (ch_addr),
    .ch_wdata_i      (ch_wdata),
    .ch_ack_o        (ch_ack),
    .ch_rdata_o      (ch_rdata),
    .hb_request_o    (hb_request),
    .hb_address_o    (hb_address),
    .hb_write_data_o (hb_write_data),
    .hb_read_data_i  (hb_read_data),
    .hb_busy_i       (hb_busy),
    .arb_busy_o      (arb_busy)
  );

  always #5 clk = ~clk;

  // Host model: busy rises the cycle after a request, stays up busy_cycles, data with the fall.
  always begin
    @(negedge clk);
    if (hb_request !== HARZ80_NONE) begin
      checks++;
      if (hb_busy !== 1'b0) begin
        errors++;
        $display("FAIL host_req_while_busy: busy=%b, required 0", hb_busy);
      end
      log_kind.push_back(hb_request);
      log_addr.push_back(hb_address);
      log_data.push_back(hb_write_data);
      host_rd = harz_is_read(hb_request);
      @(posedge clk);
      #1 hb_busy = 1'b1;
      @(negedge clk);
      checks++;
      if (hb_request !== HARZ80_NONE) begin
        errors++;
        $display("FAIL req_one_cycle: request=%h in second cycle, required NONE", hb_request);
      end
      repeat (busy_cycles) @(posedge clk);
      #1 hb_busy = 1'b0;
      if (host_rd) hb_read_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (ch_ack[c] === 1'b1) begin
        ack_cnt++;
        ack_order.push_back(c);
        ack_rdata.push_back(ch_rdata);
      end
    end
  end

  task automatic clear_logs();
    log_kind.delete();
    log_addr.delete();
    log_data.delete();
    rd_q.delete();
  endtask

  task automatic set_ch(input int ch, input harz_req_t kind, input logic [2:0] len,
                        input logic [15:0] addr, input logic [31:0] wdata);
    ch_kind[ch*4 +: 4]   = kind;
    ch_len[ch*3 +: 3]    = len;
    ch_addr[ch*16 +: 16] = addr;
    ch_wdata[ch*32 +: 32] = wdata;
  endtask

  task automatic wait_ack(input int ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ch_ack[ch] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hb_request, hb_address, hb_write_data, ch_ack, ch_rdata, arb_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%h addr=%h wd=%h ack=%b rdata=%h busy=%b, required 0",
               hb_request, hb_address, hb_write_data, ch_ack, ch_rdata, arb_busy);
    end
    reset_n = 1'b1;
    settle();
  endtask

  task automatic test_single_read();
    bit ok;
    clear_logs();
    busy_cycles = 2;
    rd_q.push_back(8'hA5);
    set_ch(0, HARZ80_MEM_READ_1, 3'd1, 16'h1234, 32'h0);
    ch_req[0] = 1'b1;
    wait_ack(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_read_ack: got no ack, required one"); end
    checks++;
    if (ch_rdata !== 32'h000000A5) begin
      errors++; $display("FAIL single_read_rdata: got %h, required 000000a5", ch_rdata);
    end
    @(posedge clk);
    #1 ch_req[0] = 1'b0;
    settle();
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 16'h1234 || log_kind[0] !== HARZ80_MEM_READ_1) begin
      errors++;
      $display("FAIL single_read_bus: %0d requests first addr %h, required 1 at 1234",
               log_addr.size(), log_addr[0]);
    end
  endtask

  task automatic test_burst_write();
    bit ok;
    logic [15:0] exp_a [4];
    logic [7:0]  exp_d [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    busy_cycles = 1;
    set_ch(1, HARZ80_MEM_WRITE_1, 3'd4, 16'hFFFE, 32'h44332211);
    ch_req[1] = 1'b1;
    wait_ack(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_write_ack: got no ack, required one"); end
    checks++;
    if (ch_rdata !== 32'h0) begin
      errors++; $display("FAIL burst_write_rdata: got %h, required 0", ch_rdata);
    end
    @(posedge clk);
    #1 ch_req[1] = 1'b0;
    settle();
    checks++;
    if (log_addr.size() != 4) begin
      errors++; $display("FAIL burst_write_count: got %0d writes, required 4", log_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL burst_write_byte%0d: got %h/%h, required %h/%h", i, log_addr[i],
                 log_data[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_io_read();
    bit ok;
    clear_logs();
    busy_cycles = 2;
    rd_q.push_back(8'h5A);
    rd_q.push_back(8'hC3);
    set_ch(1, HARZ80_IO_READ, 3'd2, 16'h00A2, 32'h0);
    ch_req[1] = 1'b1;
    wait_ack(1, ok);
    checks++;
    if (!ok || ch_rdata !== 32'h0000C35A) begin
      errors++; $display("FAIL io_read_rdata: ack=%b rdata %h, required 1 0000c35a", ok, ch_rdata);
    end
    @(posedge clk);
    #1 ch_req[1] = 1'b0;
    settle();
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 16'h00A2 || log_addr[1] !== 16'h00A2) begin
      errors++;
      $display("FAIL io_read_port: %0d requests at %h,%h, required 2 at 00a2",
               log_addr.size(), log_addr[0], log_addr[1]);
    end
  endtask

  task automatic test_round_robin();
    int n0;
    logic [31:0] exp_r [4];
    exp_r = '{32'h10, 32'h20, 32'h30, 32'h40};
    clear_logs();
    busy_cycles = 1;
    rd_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    set_ch(0, HARZ80_MEM_READ_1, 3'd1, 16'h0100, 32'h0);
    set_ch(1, HARZ80_MEM_READ_1, 3'd1, 16'h0200, 32'h0);
    n0 = ack_order.size();
    ch_req = 2'b11;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (ack_order.size() >= n0 + 4) break;
    end
    @(posedge clk);
    #1 ch_req = 2'b00;
    settle();
    checks++;
    if (ack_order.size() != n0 + 4) begin
      errors++; $display("FAIL rr_count: got %0d acks, required 4", ack_order.size() - n0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ack_order[n0+k] != (k % 2) || ack_rdata[n0+k] !== exp_r[k]) begin
        errors++;
        $display("FAIL rr_grant%0d: ch %0d rdata %h, required ch %0d rdata %h", k,
                 ack_order[n0+k], ack_rdata[n0+k], k % 2, exp_r[k]);
      end
    end
  endtask

  task automatic test_len_edges();
    int lat;
    bit ok;
    clear_logs();
    set_ch(0, HARZ80_MEM_READ_1, 3'd0, 16'h5555, 32'h0);
    ch_req[0] = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ch_ack[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 2 || ch_rdata !== 32'h0) begin
      errors++; $display("FAIL len0_ack: latency %0d rdata %h, required 2 and 0", lat, ch_rdata);
    end
    @(posedge clk);
    #1 ch_req[0] = 1'b0;
    settle();
    checks++;
    if (log_addr.size() != 0) begin
      errors++; $display("FAIL len0_bus: got %0d requests, required 0", log_addr.size());
    end
    clear_logs();
    busy_cycles = 1;
    rd_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    set_ch(0, HARZ80_MEM_READ_1, 3'd7, 16'h2000, 32'h0);
    ch_req[0] = 1'b1;
    wait_ack(0, ok);
    checks++;
    if (!ok || ch_rdata !== 32'h04030201) begin
      errors++; $display("FAIL len7_rdata: ack=%b rdata %h, required 1 04030201", ok, ch_rdata);
    end
    @(posedge clk);
    #1 ch_req[0] = 1'b0;
    settle();
    checks++;
    if (log_addr.size() != 4 || log_addr[3] !== 16'h2003) begin
      errors++;
      $display("FAIL len7_clamp: %0d requests last addr %h, required 4 ending 2003",
               log_addr.size(), log_addr[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int acks0;
    int n0;
    bit ok;
    clear_logs();
    busy_cycles = 3;
    set_ch(0, HARZ80_MEM_WRITE_1, 3'd4, 16'h3000, 32'hDDCCBBAA);
    ch_req[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (log_addr.size() >= 2) break;
    end
    @(negedge clk);
    checks++;
    if (hb_busy !== 1'b1 || log_addr.size() != 2) begin
      errors++;
      $display("FAIL rst_setup: busy=%b requests %0d, required 1 and 2", hb_busy, log_addr.size());
    end
    @(posedge clk);
    #1;
    checks++;
    if (arb_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: arb_busy=%b, required 1", arb_busy);
    end
    acks0 = ack_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({hb_request, hb_address, hb_write_data, ch_ack, ch_rdata, arb_busy} !== '0) begin
      errors++;
      $display("FAIL rst_async: req=%h addr=%h wd=%h ack=%b rdata=%h busy=%b, required 0",
               hb_request, hb_address, hb_write_data, ch_ack, ch_rdata, arb_busy);
    end
    ch_req = 2'b00;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    settle();
    checks++;
    if (ack_cnt != acks0 || log_addr.size() != 2) begin
      errors++;
      $display("FAIL rst_no_ack: %0d acks %0d requests after reset, required 0 and 2",
               ack_cnt - acks0, log_addr.size());
    end
    busy_cycles = 1;
    rd_q = '{8'h77, 8'h88};
    set_ch(0, HARZ80_MEM_READ_1, 3'd1, 16'h4000, 32'h0);
    set_ch(1, HARZ80_MEM_READ_1, 3'd1, 16'h4100, 32'h0);
    n0 = ack_order.size();
    ch_req = 2'b11;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (ack_order.size() > n0) break;
    end
    checks++;
    if (ack_order.size() <= n0 || ack_order[n0] != 0 || ack_rdata[n0] !== 32'h77) begin
      errors++;
      $display("FAIL rst_ptr: first ch %0d rdata %h, required ch 0 rdata 00000077",
               ack_order[n0], ack_rdata[n0]);
    end
    @(posedge clk);
    #1 ch_req[0] = 1'b0;
    wait_ack(1, ok);
    checks++;
    if (!ok || ch_rdata !== 32'h88) begin
      errors++; $display("FAIL rst_second: ack=%b rdata %h, required 1 00000088", ok, ch_rdata);
    end
    @(posedge clk);
    #1 ch_req[1] = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_io_read();
    test_round_robin();
    test_len_edges();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
